// File: rtl/fp_dispatcher.sv
// fp_dispatcher: pops the scheduler-selected queue, presents the packet on a valid/ready port, counts served packets.
module fp_dispatcher #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_SIZE = 64,
  parameter int SETTLE_CYCLES = 2,
  parameter int COUNT_SIZE = 16,
  localparam int QW = $clog2(NUMBER_OF_QUEUES)
) (
  input  logic clock,
  input  logic reset,
  input  logic [QW-1:0] selection,
  input  logic [NUMBER_OF_QUEUES-1:0] queue_valid,
  input  logic [NUMBER_OF_QUEUES-1:0][DATA_SIZE-1:0] queue_data,
  output logic [NUMBER_OF_QUEUES-1:0] queue_pop,
  output logic out_valid,
  input  logic out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [QW-1:0] out_queue_id,
  output logic [NUMBER_OF_QUEUES-1:0][COUNT_SIZE-1:0] served_count
);
  typedef enum logic [1:0] {IDLE, SETTLE, LOAD, SEND} state_t;
  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [NUMBER_OF_QUEUES-1:0] prev_valid;
  logic hit, take;
  assign hit = queue_valid[selection];
  assign take = state == LOAD && hit;
  assign out_valid = state == SEND;
  assign queue_pop = take ? NUMBER_OF_QUEUES'(1) << selection : '0;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (|queue_valid) begin
        state_nx = SETTLE;
        cnt_nx = RELOAD;
      end
      // any change in the non-empty flags restarts the wait so the scheduler output can catch up
      SETTLE: if (queue_valid != prev_valid) cnt_nx = RELOAD;
        else if (cnt == 4'd0) state_nx = LOAD;
        else cnt_nx = cnt - 4'd1;
      LOAD: state_nx = hit ? SEND : IDLE;
      SEND: if (out_ready) begin
        state_nx = |queue_valid ? SETTLE : IDLE;
        cnt_nx = RELOAD;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      prev_valid <= '0;
      out_data <= '0;
      out_queue_id <= '0;
      served_count <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      prev_valid <= queue_valid;
      if (take) begin
        out_data <= queue_data[selection];
        out_queue_id <= selection;
      end
      if (out_valid && out_ready && !(&served_count[out_queue_id]))
        served_count[out_queue_id] <= served_count[out_queue_id] + COUNT_SIZE'(1);
    end
endmodule

// File: tb/tb_fp_dispatcher.sv
// tb_fp_dispatcher: directed and randomized checks of fp_dispatcher against a queue/scoreboard model.
module tb_fp_dispatcher;
  localparam int NQ = 4, DW = 64, SC = 2, CW = 4;
  logic clock = 0, reset = 1;
  logic [1:0] selection;
  logic [NQ-1:0] queue_valid, queue_pop;
  logic [NQ-1:0][DW-1:0] queue_data;
  logic out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [1:0] out_queue_id;
  logic [NQ-1:0][CW-1:0] served_count;

  fp_dispatcher #(.NUMBER_OF_QUEUES(NQ), .DATA_SIZE(DW), .SETTLE_CYCLES(SC), .COUNT_SIZE(CW)) dut (
    .clock(clock), .reset(reset), .selection(selection), .queue_valid(queue_valid),
    .queue_data(queue_data), .queue_pop(queue_pop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_queue_id(out_queue_id), .served_count(served_count));

  always #5 clock = ~clock;

  logic [DW-1:0] fifo [NQ][$];
  int cnt_m [NQ];
  int n_cmp = 0, n_bad = 0, cyc = 0, n_pops = 0, pop_cyc = 0, rise_cyc = 0;
  bit pending = 0, ovr = 0, rv = 0;
  logic [DW-1:0] exp_data = '0;
  int exp_id = 0;
  logic [1:0] ovr_sel = 0, sched_sel = 0;
  logic [NQ-1:0] last_pop = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // fixed-priority scheduler: lowest non-empty index wins, id 0 when all empty
  function automatic logic [1:0] prio(input logic [NQ-1:0] v);
    for (int i = NQ - 1; i >= 0; i--) if (v[i]) prio = 2'(i);
    if (v == 0) prio = 0;
  endfunction

  task automatic refresh();
    for (int i = 0; i < NQ; i++) begin
      queue_valid[i] = fifo[i].size() > 0;
      queue_data[i] = '0;
      if (fifo[i].size() > 0) queue_data[i] = fifo[i][0];
    end
    selection = ovr ? ovr_sel : sched_sel;
  endtask

  task automatic push(input int q, input logic [DW-1:0] d);
    fifo[q].push_back(d);
    refresh();
  endtask

  task automatic tick();
    logic [NQ-1:0] p, v;
    logic ov, ordy;
    logic [DW-1:0] od;
    logic [1:0] oid, idx;
    #1;
    p = queue_pop; v = queue_valid; ov = out_valid; ordy = out_ready; od = out_data; oid = out_queue_id;
    idx = prio(p);
    if (!reset && p != 0) begin
      n_pops++; pop_cyc = cyc; last_pop = p;
      chk("pop_onehot", 64'($onehot(p)), 1);
      chk("pop_matches_selection", p, 4'(1) << selection);
      chk("pop_nonempty", 64'((p & v) != 0), 1);
      chk("pop_while_in_flight", 64'(pending), 0);
      chk("pop_during_valid", 64'(ov), 0);
      pending = 1; exp_id = idx; exp_data = '0;
      if (fifo[idx].size() > 0) exp_data = fifo[idx][0];
    end
    if (!reset && ov && ordy) begin
      chk("accept_expected", 64'(pending), 1);
      chk("accept_data", od, exp_data);
      chk("accept_id", oid, exp_id);
      pending = 0;
      if (cnt_m[exp_id] < 15) cnt_m[exp_id]++;
    end
    @(posedge clock);
    cyc++;
    sched_sel = prio(v);
    #1;
    if (!reset && p != 0 && fifo[idx].size() > 0) void'(fifo[idx].pop_front());
    refresh();
    if (out_valid && !rv) rise_cyc = cyc;
    rv = out_valid;
  endtask

  task automatic wait_valid(input string tag, input int lim);
    int k = 0;
    while (!out_valid && k < lim) begin tick(); k++; end
    chk({tag, "_valid_timeout"}, 64'(out_valid), 1);
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int k = 0;
    bit busy = 1;
    while (busy && k < lim) begin
      busy = pending || out_valid;
      for (int i = 0; i < NQ; i++) if (fifo[i].size() > 0) busy = 1;
      if (busy) begin tick(); k++; end
    end
    chk({tag, "_drain_timeout"}, 64'(busy), 0);
  endtask

  task automatic do_reset();
    reset = 1;
    pending = 0;
    for (int i = 0; i < NQ; i++) cnt_m[i] = 0;
    repeat (3) tick();
    reset = 0;
  endtask

  initial begin
    int c, a, np;
    logic [DW-1:0] d;
    out_ready = 0;
    for (int i = 0; i < NQ; i++) cnt_m[i] = 0;
    refresh();
    repeat (10) tick();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_queue_pop", queue_pop, 0);
    chk("rst_served", 64'(served_count), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_queue_id, 0);
    reset = 0;
    tick();

    // first arrival latency and single pop
    out_ready = 1; c = cyc; np = n_pops;
    push(2, 64'hA5);
    wait_valid("lat", 20);
    chk("lat_pop_cycle", 64'(pop_cyc - c), SC + 1);
    chk("lat_rise_cycle", 64'(rise_cyc - c), SC + 2);
    chk("lat_pop_value", last_pop, 4'b0100);
    chk("lat_data", out_data, 64'hA5);
    chk("lat_id", out_queue_id, 2);
    chk("lat_npops", 64'(n_pops - np), 1);
    tick();
    chk("lat_served2", served_count[2], 1);
    chk("lat_valid_drop", 64'(out_valid), 0);

    // backpressure hold
    out_ready = 0;
    push(1, 64'h1234_5678_9abc_def0);
    wait_valid("bp", 20);
    d = out_data; np = n_pops;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_valid_hold", 64'(out_valid), 1);
      chk("bp_data_hold", out_data, d);
    end
    chk("bp_no_pop", 64'(n_pops - np), 0);
    chk("bp_served_hold", served_count[1], 0);
    out_ready = 1;
    tick();
    chk("bp_served1", served_count[1], 1);
    chk("bp_valid_drop", 64'(out_valid), 0);

    // selection pointing at an empty queue
    ovr = 1; ovr_sel = 0; np = n_pops;
    push(1, 64'hBEEF);
    repeat (12) tick();
    chk("empty_sel_no_pop", 64'(n_pops - np), 0);
    chk("empty_sel_no_valid", 64'(out_valid), 0);
    ovr = 0;
    refresh();
    wait_valid("resel", 20);
    chk("resel_data", out_data, 64'hBEEF);
    chk("resel_id", out_queue_id, 1);
    tick();
    chk("resel_served1", served_count[1], 2);

    // arrival one cycle before settle expiry restarts the wait
    push(0, 64'h11);
    tick(); tick();
    a = cyc;
    push(3, 64'h33);
    wait_valid("reload", 20);
    chk("reload_pop_cycle", 64'(pop_cyc - a), SC + 1);
    chk("reload_first_id", out_queue_id, 0);
    tick();
    wait_valid("reload2", 20);
    chk("reload_second_id", out_queue_id, 3);
    chk("reload_second_data", out_data, 64'h33);
    tick();

    // reset during SEND clears immediately
    out_ready = 0;
    push(2, 64'h77);
    wait_valid("midrst", 20);
    reset = 1;
    pending = 0;
    for (int i = 0; i < NQ; i++) cnt_m[i] = 0;
    #1;
    chk("midrst_valid", 64'(out_valid), 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_id", out_queue_id, 0);
    chk("midrst_pop", queue_pop, 0);
    chk("midrst_served", 64'(served_count), 0);
    do_reset();

    // counter saturation
    out_ready = 1;
    for (int i = 0; i < 17; i++) push(0, 64'(i + 1));
    wait_idle("sat", 500);
    chk("sat_q0", served_count[0], 15);
    for (int i = 1; i < NQ; i++) chk("sat_others", served_count[i], 0);

    // randomized traffic against the scoreboard
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) push(int'($urandom_range(NQ - 1)), {$urandom, $urandom});
      out_ready = $urandom_range(2) != 0;
      tick();
    end
    out_ready = 1;
    wait_idle("rand", 3000);
    for (int i = 0; i < NQ; i++) chk("rand_served", served_count[i], 64'(cnt_m[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
